mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words stored; power of two, 2..1024.
REQ-002 Parameter LATENCY, default 2: cycles from request capture to ack; legal range 1..15.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port req  input  1: initiator request strobe; held high by the initiator until ack.
REQ-006 Port we  input  1: 1 = write, 0 = read; sampled with req.
REQ-007 Port addr  input  32: byte address; sampled with req.
REQ-008 Port wdata  input  32: write data; sampled with req.
REQ-009 Port ack  output  1: one-cycle completion pulse.
REQ-010 Port rdata  output  32: read data; valid while ack is high after a read.
REQ-011 Port busy  output  1: high in any state other than IDLE.
REQ-012 Port err  output  1: misalignment error qualifier, valid with ack.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; one-hot or binary encoding at implementer's discretion.
REQ-014 IDLE: on a rising edge with req=1, capture we/addr/wdata and load the 4-bit counter with LATENCY-1; next state WAIT if LATENCY>1, else RESP.
REQ-015 WAIT: counter decrements each edge; when the counter equals 1, next state RESP.
REQ-016 The request is captured at edge N; ack is high for exactly the cycle following edge N+LATENCY.
REQ-017 Writes commit to the array at the edge entering RESP; no array change in any other state.
REQ-018 Reads: rdata is loaded from the array at the edge entering RESP and holds that value until the next completed read.
REQ-019 Word index = captured addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH.
REQ-020 RESP: unconditional transition to IDLE on the next edge; req is ignored in RESP.
REQ-021 req=1 in IDLE after RESP is treated as a new request, so back-to-back transactions are spaced LATENCY+1 cycles apart.
REQ-022 Changes to we/addr/wdata after capture have no effect on the transaction in flight.
REQ-023 busy is combinational from state: 0 in IDLE, 1 in WAIT and RESP.

Reset
REQ-024 reset=1 forces state IDLE, counter 0, ack 0, err 0, and rdata 32'h0 immediately, independent of clk.
REQ-025 Reset during WAIT aborts the transaction: no array write occurs and no ack is produced.
REQ-026 Array contents are not cleared by reset; only control state and outputs are.
REQ-027 Reset deasserted with req=1 already high: request captured at the first rising edge after deassertion.

Configuration
REQ-028 Macro MEMRESP_ALIGN_CHECK_EN enables misalignment checking.
REQ-029 Macro defined: captured addr[1:0]!=0 suppresses the write, sets rdata to 32'h0 for reads, and asserts err together with ack; timing is unchanged.
REQ-030 Macro undefined: addr[1:0] is ignored, all accesses proceed normally, and err is tied to 0; the port list is identical in both builds.

Verification
REQ-031 LATENCY=2: write 32'hDEADBEEF to addr 0x10, then read 0x10 -> ack 2 cycles after each capture edge, and rdata=32'hDEADBEEF with the read ack.
REQ-032 LATENCY=1: req held high continuously for reads of 0x0, 0x4, and 0x8 -> acks every 2 cycles, and busy is low only in the IDLE cycles between them.
REQ-033 DEPTH=64: write 32'h1234 to 0x104, then read 0x004 -> rdata=32'h1234 (wrap-around).
REQ-034 Write 32'hAAAA to 0x20, then start a write of 32'h5555 to 0x20 and assert reset in WAIT -> no ack; a later read of 0x20 returns 32'hAAAA.
REQ-035 With MEMRESP_ALIGN_CHECK_EN defined: write 32'hFFFF to 0x22 -> ack with err=1, and a read of 0x20 is unchanged; without the macro, the same write sets word 0x20 to 32'hFFFF and err=0.
REQ-036 Change addr and wdata during WAIT of a write to 0x30 -> data lands at 0x30 with the originally captured wdata.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory with a fixed-latency req/ack handshake.
// Define MEMRESP_ALIGN_CHECK_EN to flag misaligned accesses with err.
`timescale 1ns/1ps
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        enter_resp;

  logic [31:0] mem_q [DEPTH];

  // With LATENCY=1 the array is accessed on the capture edge itself,
  // so the live request fields are used while still in IDLE.
  logic          acc_live;
  logic          acc_we;
  logic [31:0]   acc_addr, acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_bad, cap_bad;

  assign acc_live  = (state_q == ST_IDLE);
  assign acc_we    = acc_live ? we    : we_q;
  assign acc_addr  = acc_live ? addr  : addr_q;
  assign acc_wdata = acc_live ? wdata : wdata_q;
  assign acc_idx   = acc_addr[AW+1:2];

`ifdef MEMRESP_ALIGN_CHECK_EN
  assign acc_bad = (acc_addr[1:0] != 2'b00);
  assign cap_bad = (addr_q[1:0] != 2'b00);
`else
  assign acc_bad = 1'b0;
  assign cap_bad = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:AW+2], acc_addr[1:0], addr_q[1:0]};

  // NOTE: every variable is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = ST_WAIT;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp && !acc_we) begin
      rdata_d = acc_bad ? 32'h0 : mem_q[acc_idx];
    end
    ack_d = (state_q == ST_RESP);
    err_d = (state_q == ST_RESP) && cap_bad;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (state_q == ST_IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; reset only gates the write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && acc_we && !acc_bad) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != ST_IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2 and LATENCY=1 instances).
`timescale 1ns/1ps
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        ack, busy, err;
  logic [31:0] rdata;
  logic        req1, we1;
  logic [31:0] addr1, wdata1;
  logic        ack1, busy1, err1;
  logic [31:0] rdata1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_rd  = 32'h0;
  logic [31:0] last_rd1 = 32'h0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .err(err)
  );

  mem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ack(ack1), .rdata(rdata1), .busy(busy1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance; req held until ack is seen.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input bit perturb, input bit rel);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    if (rel) reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_ack", 32'(ack), 32'd0);
    if (perturb) begin
      addr = a + 32'h4; wdata = 32'h0BAD_0BAD;
    end
    @(negedge clk);
    check("resp_busy", 32'(busy), 32'd1);
    check("resp_ack", 32'(ack), 32'd0);
    @(negedge clk);
    check("ack", 32'(ack), 32'd1);
    check("ack_busy", 32'(busy), 32'd0);
    check("ack_err", 32'(err), 32'(exp_err));
    if (!w) last_rd = exp_rd;
    check("rdata", rdata, last_rd);
    req = 1'b0;
    @(negedge clk);
    check("ack_pulse", 32'(ack), 32'd0);
  endtask

  task automatic txn1(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd);
    @(negedge clk);
    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    @(posedge clk);
    @(negedge clk);
    check("l1_resp_busy", 32'(busy1), 32'd1);
    check("l1_resp_ack", 32'(ack1), 32'd0);
    @(negedge clk);
    check("l1_ack", 32'(ack1), 32'd1);
    check("l1_ack_busy", 32'(busy1), 32'd0);
    if (!w) last_rd1 = exp_rd;
    check("l1_rdata", rdata1, last_rd1);
    req1 = 1'b0;
  endtask

  initial begin
    logic [31:0] l1_addr [3];
    logic [31:0] l1_data [3];
    l1_addr[0] = 32'h0;  l1_addr[1] = 32'h4;  l1_addr[2] = 32'h8;
    l1_data[0] = 32'hA0; l1_data[1] = 32'hA4; l1_data[2] = 32'hA8;

    reset = 1'b1;
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ack1", 32'(ack1), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // LATENCY=1: preload three words, then stream reads with req held high.
    for (int i = 0; i < 3; i++) txn1(1'b1, l1_addr[i], l1_data[i], 32'h0);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = l1_addr[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("l1s_busy", 32'(busy1), 32'd1);
      check("l1s_ack0", 32'(ack1), 32'd0);
      @(negedge clk);
      check("l1s_ack", 32'(ack1), 32'd1);
      check("l1s_idle", 32'(busy1), 32'd0);
      check("l1s_rdata", rdata1, l1_data[i]);
      if (i < 2) addr1 = l1_addr[i+1];
    end
    req1 = 1'b0;
    @(negedge clk);
    check("l1s_end_ack", 32'(ack1), 32'd0);
    check("l1s_end_busy", 32'(busy1), 32'd0);

    // Basic write/read and address wrap-around.
    txn(1'b1, 32'h10,  32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0);
    txn(1'b0, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    txn(1'b1, 32'h104, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0);
    txn(1'b0, 32'h004, 32'h0, 32'h1234, 1'b0, 1'b0, 1'b0);

    // Fields changed mid-transaction must not affect the captured write.
    txn(1'b1, 32'h34, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0);
    txn(1'b1, 32'h30, 32'h3030_3030, 32'h0, 1'b0, 1'b1, 1'b0);
    txn(1'b0, 32'h30, 32'h0, 32'h3030_3030, 1'b0, 1'b0, 1'b0);
    txn(1'b0, 32'h34, 32'h0, 32'h11, 1'b0, 1'b0, 1'b0);

    // Reset in WAIT aborts the write; a request already high at release is taken.
    txn(1'b1, 32'h20, 32'hAAAA, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h5555;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", rdata, 32'h0);
    req = 1'b0;
    last_rd = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_ack", 32'(ack), 32'd0);
    end
    req = 1'b1; we = 1'b0; addr = 32'h20;
    txn(1'b0, 32'h20, 32'h0, 32'hAAAA, 1'b0, 1'b0, 1'b1);

    // Misaligned write.
`ifdef MEMRESP_ALIGN_CHECK_EN
    txn(1'b1, 32'h22, 32'hFFFF, 32'h0, 1'b1, 1'b0, 1'b0);
    txn(1'b0, 32'h20, 32'h0, 32'hAAAA, 1'b0, 1'b0, 1'b0);
    txn(1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
`else
    txn(1'b1, 32'h22, 32'hFFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    txn(1'b0, 32'h20, 32'h0, 32'hFFFF, 1'b0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
